// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares the single read port of the sprite ROM among NUM_REQ renderers.
//   Each renderer asks for a burst of consecutive words; bursts are granted
//   round-robin and issued one address per cycle. Read data comes back tagged
//   with the owning requester id and a last-word flag.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req[NUM_REQ]        per-requester burst request (level, held until gnt)
//   req_addr            packed base addresses, slice i belongs to requester i
//   req_len             packed burst lengths (0 is treated as 1)
//   gnt                 one-cycle grant pulse, one-hot or zero
//   rom_addr, rom_en    ROM read address and its valid strobe
//   rom_data            ROM read data, ROM_LATENCY cycles after rom_addr
//   rsp_valid/id/last   response tag aligned with rom_data
//   rsp_data            rom_data passed straight through
//   busy                a burst is being issued
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int LEN_W       = 6,
  parameter int ROM_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [ADDR_W-1:0]          rom_addr,
  output logic                       rom_en,
  input  logic [DATA_W-1:0]          rom_data,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_last,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr, cur_id, win;
  logic               win_found, start, last_beat, arb_en;
  logic [LEN_W-1:0]   len_q, cnt;
  logic [NUM_REQ-1:0] cand;
  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];
  logic [LEN_W-1:0]   len_arr  [NUM_REQ];

  // Response tag delay line, one entry per cycle of ROM latency
  logic [ROM_LATENCY-1:0] vld_p, last_p;
  logic [ID_W-1:0]        id_p [ROM_LATENCY];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
      len_arr[i]  = req_len[i*LEN_W +: LEN_W];
    end
  end

  // cnt counts beats already placed on rom_addr, so the current beat is the
  // last one when it equals the latched length.
  assign last_beat = (state == BURST) && (cnt == len_q);
  assign arb_en    = (state == IDLE) || last_beat;
  // A requester still sees its own grant this cycle and only drops req next
  // cycle, so it must not win again while gnt is high.
  assign cand      = req & ~gnt;
  assign start     = arb_en && win_found;

  always_comb begin
    logic [ID_W-1:0] idx;
    win_found = 1'b0;
    win       = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(rr) + i) % NUM_REQ);
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = BURST;
      BURST:   if (last_beat && !win_found) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue stage: grant, address generation, beat counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= '0;
      gnt      <= '0;
      rom_addr <= '0;
      cnt      <= '0;
      len_q    <= '0;
      cur_id   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= '0;
      if (start) begin
        gnt      <= NUM_REQ'(1) << win;
        rr       <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        rom_addr <= addr_arr[win];
        len_q    <= (len_arr[win] == '0) ? LEN_W'(1) : len_arr[win];
        cnt      <= LEN_W'(1);
        cur_id   <= win;
      end else if (state == BURST && !last_beat) begin
        rom_addr <= rom_addr + 1'b1;
        cnt      <= cnt + 1'b1;
      end
    end
  end

  assign rom_en = (state == BURST);
  assign busy   = (state == BURST);

  // Response stages: tag follows the read through the ROM pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p  <= '0;
      last_p <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) id_p[i] <= '0;
    end else begin
      vld_p[0]  <= rom_en;
      last_p[0] <= last_beat;
      id_p[0]   <= cur_id;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        last_p[i] <= last_p[i-1];
        id_p[i]   <= id_p[i-1];
      end
    end
  end

  assign rsp_valid = vld_p[ROM_LATENCY-1];
  assign rsp_last  = last_p[ROM_LATENCY-1];
  assign rsp_id    = id_p[ROM_LATENCY-1];
  assign rsp_data  = rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Testbench for sprite_rom_arbiter: randomized and directed requesters, a
// transaction-level reference model filling expectation queues, and a monitor
// that pops and compares every cycle.
module tb_sprite_rom_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 10;
  localparam int DW  = 16;
  localparam int LW  = 6;
  localparam int LAT = 3;
  localparam int IW  = $clog2(NR);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*LW-1:0]  req_len = '0;
  logic [NR-1:0]     gnt;
  logic [AW-1:0]     rom_addr;
  logic              rom_en;
  logic [DW-1:0]     rom_data;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic              rsp_last;
  logic [DW-1:0]     rsp_data;
  logic              busy;

  sprite_rom_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ROM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_len(req_len),
    .gnt(gnt), .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_last(rsp_last),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // ROM model: data = address, LAT cycles after the address is presented
  logic [AW-1:0] rp [LAT];
  always @(posedge clk) begin
    rp[0] <= rom_addr;
    for (int i = 1; i < LAT; i++) rp[i] <= rp[i-1];
  end
  assign rom_data = DW'(rp[LAT-1]);

  typedef struct {int cyc; int id; int addr; bit last;} ent_t;
  ent_t gq[$];
  ent_t iq[$];
  ent_t rq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  int m_end  = -100;
  int lg_cyc = -100;
  int lg_id  = 0;
  int rr     = 0;
  bit pend [NR];
  int p_addr [NR];
  int p_len  [NR];
  bit inj [NR];
  int inj_addr [NR];
  int inj_len  [NR];
  bit rnd_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive_req();
    for (int i = 0; i < NR; i++) begin
      req[i]               = pend[i];
      req_addr[i*AW +: AW] = AW'(p_addr[i]);
      req_len[i*LW +: LW]  = LW'(p_len[i]);
    end
  endtask

  task automatic model_reset();
    gq.delete(); iq.delete(); rq.delete();
    m_end = -100; lg_cyc = -100; lg_id = 0; rr = 0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 0; inj[i] = 0; p_addr[i] = 0; p_len[i] = 0;
    end
    drive_req();
  endtask

  // One model step at clock edge number cyc, using the requests the DUT saw.
  task automatic step();
    int prev;
    prev = (lg_cyc == cyc - 1) ? lg_id : -1;
    // Arbitrate when nothing was issued last cycle or last cycle was the final beat
    if (cyc - 1 >= m_end) begin
      for (int i = 0; i < NR; i++) begin
        int idx, n;
        idx = (rr + i) % NR;
        if (req[idx] && idx != prev) begin
          n = (p_len[idx] == 0) ? 1 : p_len[idx];
          gq.push_back('{cyc, idx, 0, 1'b0});
          for (int k = 0; k < n; k++) begin
            iq.push_back('{cyc + k, idx, (p_addr[idx] + k) % (1 << AW), k == n - 1});
            rq.push_back('{cyc + k + LAT, idx, (p_addr[idx] + k) % (1 << AW), k == n - 1});
          end
          m_end  = cyc + n - 1;
          lg_cyc = cyc;
          lg_id  = idx;
          rr     = (idx + 1) % NR;
          break;
        end
      end
    end
    #1;
    if (prev >= 0) pend[prev] = 0;
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && i != prev) begin
        if (inj[i]) begin
          pend[i] = 1; p_addr[i] = inj_addr[i]; p_len[i] = inj_len[i]; inj[i] = 0;
        end else if (rnd_on && $urandom_range(0, 5) == 0) begin
          pend[i]   = 1;
          p_addr[i] = int'($urandom_range(0, (1 << AW) - 1));
          p_len[i]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63))
                                                  : int'($urandom_range(0, 4));
        end
      end
    end
    drive_req();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) step();
    end
  end

  // Monitor: every cycle, compare DUT outputs against the queue heads
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        int eg, c;
        c  = cyc;
        eg = 0;
        if (gq.size() > 0 && gq[0].cyc == c) begin
          eg = 1 << gq[0].id;
          void'(gq.pop_front());
        end
        chk("gnt", int'(gnt), eg);
        if (iq.size() > 0 && iq[0].cyc == c) begin
          chk("rom_en", int'(rom_en), 1);
          chk("busy", int'(busy), 1);
          chk("rom_addr", int'(rom_addr), iq[0].addr);
          void'(iq.pop_front());
        end else begin
          chk("rom_en_idle", int'(rom_en), 0);
          chk("busy_idle", int'(busy), 0);
        end
        if (rq.size() > 0 && rq[0].cyc == c) begin
          chk("rsp_valid", int'(rsp_valid), 1);
          chk("rsp_id", int'(rsp_id), rq[0].id);
          chk("rsp_last", int'(rsp_last), int'(rq[0].last));
          chk("rsp_data", int'(rsp_data), rq[0].addr);
          void'(rq.pop_front());
        end else begin
          chk("rsp_valid_idle", int'(rsp_valid), 0);
        end
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_rom_en", int'(rom_en), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_last", int'(rsp_last), 0);
    chk("rst_busy", int'(busy), 0);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 800; n++) begin
      bit any;
      @(posedge clk);
      #2;
      any = 0;
      for (int i = 0; i < NR; i++) any |= pend[i] | inj[i];
      if (!any && gq.size() == 0 && iq.size() == 0 && rq.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout cyc=%0d got=busy exp=idle", cyc);
  endtask

  task automatic inject(input int id, input int addr, input int len);
    inj[id] = 1; inj_addr[id] = addr; inj_len[id] = len;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    #2 rst_n = 1'b1;

    // Single burst from requester 2
    @(posedge clk); #2;
    inject(2, 'h040, 4);
    wait_idle();

    // All four requesters at once, len 2 each
    @(posedge clk); #2;
    inject(0, 'h010, 2); inject(1, 'h020, 2); inject(2, 'h030, 2); inject(3, 'h040, 2);
    wait_idle();

    // len=1 back-to-back
    @(posedge clk); #2;
    inject(0, 'h100, 1); inject(1, 'h200, 1);
    wait_idle();

    // Address wrap and zero length
    @(posedge clk); #2;
    inject(3, 'h3FE, 4);
    wait_idle();
    @(posedge clk); #2;
    inject(1, 'h155, 0);
    wait_idle();

    // Randomized traffic
    rnd_on = 1'b1;
    repeat (3000) @(posedge clk);
    #2 rnd_on = 1'b0;
    wait_idle();

    // Reset in the middle of a burst
    @(posedge clk); #2;
    inject(1, 'h100, 20);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #2;
    inject(3, 'h3FF, 3);
    wait_idle();

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
